// File: rtl/an_encoder_52bits_clk.sv
// Multi-cycle AN-code encoder: W = A*N via shift-add, one multiplier bit per cycle.
// Define ERR_INJ_EN to add the err_* ports and an INJ state that applies a +/-2^k error to W.
module an_encoder_52bits_clk #(
  parameter int A      = 131,
  parameter int A_BITS = 8,
  parameter int N_BITS = 52,
  parameter int W_BITS = 61
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] N_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_BITS-1:0] W
`ifdef ERR_INJ_EN
  ,
  input  logic              err_en,
  input  logic              err_sign,
  input  logic [5:0]        err_pos
`endif
);

  localparam int CNT_W = $clog2(A_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_INJ,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [W_BITS-1:0]   r_m;
  logic [A_BITS-1:0]   r_q;
  logic [W_BITS-1:0]   r_acc;
  logic [CNT_W-1:0]    r_count;
  logic                r_out_valid;
  logic [W_BITS-1:0]   r_w;
  logic                w_last_mul;

`ifdef ERR_INJ_EN
  localparam logic [6:0] W_BITS7 = 7'(W_BITS);

  logic                r_err_en;
  logic                r_err_sign;
  logic [5:0]          r_err_pos;
  logic [W_BITS-1:0]   w_err_mask;

  // Positions beyond the codeword produce no error but INJ is still traversed.
  assign w_err_mask = (r_err_en && ({1'b0, r_err_pos} < W_BITS7))
                      ? ({{(W_BITS-1){1'b0}}, 1'b1} << r_err_pos)
                      : '0;
`endif

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = r_out_valid;
  assign W          = r_w;
  assign w_last_mul = (r_count == CNT_W'(A_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_MUL;
`ifdef ERR_INJ_EN
      S_MUL:  if (w_last_mul) w_next = S_INJ;
`else
      S_MUL:  if (w_last_mul) w_next = S_DONE;
`endif
      S_INJ:  w_next = S_DONE;
      S_DONE: if (r_out_valid && out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m         <= '0;
      r_q         <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_w         <= '0;
`ifdef ERR_INJ_EN
      r_err_en    <= 1'b0;
      r_err_sign  <= 1'b0;
      r_err_pos   <= '0;
`endif
    end else begin
      // NOTE: non-blocking throughout, so every term reads the pre-edge register values.
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_m     <= W_BITS'(N_in);
            r_q     <= A_BITS'(A);
            r_acc   <= '0;
            r_count <= '0;
`ifdef ERR_INJ_EN
            r_err_en   <= err_en;
            r_err_sign <= err_sign;
            r_err_pos  <= err_pos;
`endif
          end
        end
        S_MUL: begin
          if (r_q[0]) r_acc <= r_acc + r_m;
          r_m     <= r_m << 1;
          r_q     <= r_q >> 1;
          r_count <= r_count + 1'b1;
        end
        S_INJ: begin
`ifdef ERR_INJ_EN
          r_acc <= r_err_sign ? (r_acc - w_err_mask) : (r_acc + w_err_mask);
`endif
        end
        S_DONE: begin
          // First DONE cycle publishes the result; W then holds until the next word.
          if (!r_out_valid) begin
            r_w         <= r_acc;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_an_encoder_52bits_clk.sv
// Self-checking bench for an_encoder_52bits_clk: directed cases plus random words
// checked against an arithmetic model of A*N (+/- injected error) mod 2^W_BITS.
module tb_an_encoder_52bits_clk;

  localparam int A      = 131;
  localparam int A_BITS = 8;
  localparam int N_BITS = 52;
  localparam int W_BITS = 61;
`ifdef ERR_INJ_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif
  localparam int LAT = A_BITS + 1 + int'(ERR_ON);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] N_in;
  logic              out_valid;
  logic              out_ready;
  logic [W_BITS-1:0] W;
  logic              err_en;
  logic              err_sign;
  logic [5:0]        err_pos;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  an_encoder_52bits_clk #(
    .A(A), .A_BITS(A_BITS), .N_BITS(N_BITS), .W_BITS(W_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .N_in      (N_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .W         (W)
`ifdef ERR_INJ_EN
    ,
    .err_en    (err_en),
    .err_sign  (err_sign),
    .err_pos   (err_pos)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer product, optional +/-2^pos, reduced mod 2^W_BITS.
  function automatic logic [60:0] model(input logic [51:0] n, input bit en, input bit sgn,
                                        input logic [5:0] pos);
    logic [63:0] p;
    logic [63:0] d;
    p = 64'(A) * 64'(n);
    if (ERR_ON && en && (int'(pos) < W_BITS)) begin
      d = 64'd1 << pos;
      p = sgn ? (p - d) : (p + d);
    end
    return p[60:0];
  endfunction

  task automatic wait_valid(input string tag, output int edges);
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    if (!out_valid) check({tag, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  task automatic send(input string tag, input logic [51:0] n, input int stall, input bit en,
                      input bit sgn, input logic [5:0] pos, input logic [60:0] exp);
    int edges;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    N_in      = n;
    out_ready = (stall == 0);
    err_en    = en;
    err_sign  = sgn;
    err_pos   = pos;
    @(posedge clk);
    @(negedge clk);
    // Garbage on the inputs while busy must be ignored.
    in_valid = 1'b0;
    N_in     = {$urandom, $urandom};
    err_en   = 1'($urandom);
    err_pos  = 6'($urandom);
    check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    wait_valid(tag, edges);
    check({tag, "_latency"}, 64'(edges), 64'(LAT));
    check({tag, "_W"}, 64'(W), 64'(exp));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_stall_W"}, 64'(W), 64'(exp));
      check({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_back_idle"}, 64'(in_ready), 64'd1);
    check({tag, "_W_hold"}, 64'(W), 64'(exp));
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          edges;
    logic [51:0] rn;
    bit          ren;
    bit          rsg;
    logic [5:0]  rps;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    N_in      = '0;
    out_ready = 1'b0;
    err_en    = 1'b0;
    err_sign  = 1'b0;
    err_pos   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_W", 64'(W), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    send("one", 52'd1, 0, 1'b0, 1'b0, 6'd0, 61'd131);
    send("ones", {52{1'b1}}, 0, 1'b0, 1'b0, 6'd0, 61'h082F_FFFF_FFFF_FF7D);
    send("zero", 52'd0, 0, 1'b0, 1'b0, 6'd0, 61'd0);
    send("stall5", 52'd1000, 5, 1'b0, 1'b0, 6'd0, 61'd131000);

    // Back-to-back: in_valid held high; second word must wait for the first handshake.
    @(negedge clk);
    in_valid  = 1'b1;
    N_in      = 52'd7;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    N_in = 52'd9;
    check("b2b_busy", 64'(in_ready), 64'd0);
    wait_valid("b2b_first", edges);
    check("b2b_first_W", 64'(W), 64'd917);
    @(posedge clk);
    @(negedge clk);
    check("b2b_first_drop", 64'(out_valid), 64'd0);
    check("b2b_idle_gap", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_second_accepted", 64'(in_ready), 64'd0);
    wait_valid("b2b_second", edges);
    check("b2b_second_latency", 64'(edges), 64'(LAT));
    check("b2b_second_W", 64'(W), 64'd1179);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_second_drop", 64'(out_valid), 64'd0);

`ifdef ERR_INJ_EN
    send("inj_plus3", 52'd5, 0, 1'b1, 1'b0, 6'd3, 61'd663);
    send("inj_minus0", 52'd5, 1, 1'b1, 1'b1, 6'd0, 61'd654);
    send("inj_wrap", 52'd0, 0, 1'b1, 1'b1, 6'd0, {61{1'b1}});
    send("inj_pos61", 52'd5, 0, 1'b1, 1'b0, 6'd61, 61'd655);
`endif

    // Reset in the middle of the multiply: word is dropped.
    @(negedge clk);
    in_valid = 1'b1;
    N_in     = 52'd12345;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_W", 64'(W), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    edges     = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (out_valid) edges++;
    end
    check("midrst_no_output", 64'(edges), 64'd0);
    out_ready = 1'b0;
    send("after_rst", 52'd3, 0, 1'b0, 1'b0, 6'd0, 61'd393);

    for (int i = 0; i < 25; i++) begin
      rn  = {$urandom, $urandom};
      ren = 1'($urandom);
      rsg = 1'($urandom);
      rps = 6'($urandom_range(0, 63));
      send($sformatf("rand%0d", i), rn, $urandom_range(0, 3), ren, rsg, rps,
           model(rn, ren, rsg, rps));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
